mgr_oob_downstream_arbiter: RTL and testbench

//  Round-robin, packet-locked arbiter that shares one Stack Bus OOB downstream channel between
//  NUM_REQ manager OOB requesters (mgr__std__oob_* per manager) in the manager array.

---
 rtl/mgr_oob_downstream_arbiter_if.sv | 51 +++++
 rtl/mgr_oob_downstream_arbiter.sv | 158 +++++++++++++++
 tb/tb_mgr_oob_downstream_arbiter.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mgr_oob_downstream_arbiter_if.sv
// ----------------------------------------------------------------------------
// mgr_oob_downstream_arbiter_if
//   Bundle of the manager-side OOB request bus and the shared Stack Bus OOB
//   downstream channel that mgr_oob_downstream_arbiter sits between.
//
//   Signals
//     mgr__arb__oob_valid  NUM_REQ         per-requester beat valid
//     mgr__arb__oob_cntl   2*NUM_REQ       per-requester cntl (01 SOM, 11 MOM, 10 EOM, 00 SOM_EOM)
//     mgr__arb__oob_type   TYPE_W*NUM_REQ  per-requester OOB type
//     mgr__arb__oob_data   DATA_W*NUM_REQ  per-requester OOB data
//     arb__mgr__oob_ready  NUM_REQ         per-requester ready (one-hot or zero)
//     arb__std__oob_valid  1               shared channel beat valid
//     arb__std__oob_cntl   2               shared channel cntl
//     arb__std__oob_type   TYPE_W          shared channel type
//     arb__std__oob_data   DATA_W          shared channel data
//     std__arb__oob_ready  1               shared channel ready
//
//   Modports
//     master : the environment (managers plus downstream channel sink)
//     slave  : the arbiter
// ----------------------------------------------------------------------------
interface mgr_oob_downstream_arbiter_if #(
    parameter int NUM_REQ = 64,
    parameter int TYPE_W  = 2,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]        mgr__arb__oob_valid;
    logic [2*NUM_REQ-1:0]      mgr__arb__oob_cntl;
    logic [TYPE_W*NUM_REQ-1:0] mgr__arb__oob_type;
    logic [DATA_W*NUM_REQ-1:0] mgr__arb__oob_data;
    logic [NUM_REQ-1:0]        arb__mgr__oob_ready;
    logic                      arb__std__oob_valid;
    logic [1:0]                arb__std__oob_cntl;
    logic [TYPE_W-1:0]         arb__std__oob_type;
    logic [DATA_W-1:0]         arb__std__oob_data;
    logic                      std__arb__oob_ready;

    modport master (
        output mgr__arb__oob_valid, mgr__arb__oob_cntl, mgr__arb__oob_type, mgr__arb__oob_data,
        output std__arb__oob_ready,
        input  arb__mgr__oob_ready,
        input  arb__std__oob_valid, arb__std__oob_cntl, arb__std__oob_type, arb__std__oob_data
    );

    modport slave (
        input  mgr__arb__oob_valid, mgr__arb__oob_cntl, mgr__arb__oob_type, mgr__arb__oob_data,
        input  std__arb__oob_ready,
        output arb__mgr__oob_ready,
        output arb__std__oob_valid, arb__std__oob_cntl, arb__std__oob_type, arb__std__oob_data
    );
endinterface

// File: rtl/mgr_oob_downstream_arbiter.sv
// ----------------------------------------------------------------------------
// mgr_oob_downstream_arbiter
//   Round-robin, packet-locked arbiter sharing one Stack Bus OOB downstream
//   channel between NUM_REQ manager OOB requesters. A grant is held from SOM
//   until the EOM (or SOM_EOM) beat transfers, so configuration packets are
//   never interleaved. Once locked the data path is a combinational mux from
//   the granted requester (no added beat latency); each new grant costs one
//   IDLE arbitration cycle.
//
//   Ports
//     clk                 in   rising-edge clock
//     reset_poweron       in   synchronous, active-low reset
//     bus                 slave modport of mgr_oob_downstream_arbiter_if
//     arb__sys__grant_id  out  current / last granted requester index
//     arb__sys__busy      out  1 while a packet is locked
//     arb__sys__timeout   out  sticky timeout flag
//
//   Optional feature (macro MGR_OOB_ARB_TIMEOUT_EN)
//     When defined, a TMO_W-bit stall counter releases a lock that has seen
//     no transfer for 2**TMO_W-1 consecutive cycles and sets a sticky
//     timeout flag. When undefined the lock is held indefinitely and
//     arb__sys__timeout is tied 0.
// ----------------------------------------------------------------------------
module mgr_oob_downstream_arbiter #(
    parameter int NUM_REQ = 64,
    parameter int TYPE_W  = 2,
    parameter int DATA_W  = 32,
    parameter int GRANT_W = 6,
    parameter int TMO_W   = 10
) (
    input  logic                         clk,
    input  logic                         reset_poweron,
    mgr_oob_downstream_arbiter_if.slave  bus,
    output logic [GRANT_W-1:0]           arb__sys__grant_id,
    output logic                         arb__sys__busy,
    output logic                         arb__sys__timeout
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    localparam logic [1:0] CNTL_EOM     = 2'b10;
    localparam logic [1:0] CNTL_SOM_EOM = 2'b00;

    logic [0:0]         state;
    logic [GRANT_W-1:0] last_grant;
    logic [GRANT_W-1:0] grant_id;

    logic [GRANT_W-1:0] rr_sel;
    logic               rr_found;
    logic               locked;
    logic               out_valid;
    logic               beat_xfer;
    logic               beat_last;
    logic               tmo_hit;

    // Per-requester fields reshaped into arrays so the granted requester can
    // be selected directly by grant_id.
    logic [1:0]        req_cntl [NUM_REQ];
    logic [TYPE_W-1:0] req_type [NUM_REQ];
    logic [DATA_W-1:0] req_data [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_cntl[g] = bus.mgr__arb__oob_cntl[2*g +: 2];
        assign req_type[g] = bus.mgr__arb__oob_type[TYPE_W*g +: TYPE_W];
        assign req_data[g] = bus.mgr__arb__oob_data[DATA_W*g +: DATA_W];
    end

    // Round-robin search: first asserting valid at last_grant+1, +2, ...
    // wrapping modulo NUM_REQ; the previous winner is checked last.
    always_comb begin
        logic [GRANT_W-1:0] idx;
        rr_sel   = last_grant;
        rr_found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = GRANT_W'((int'(last_grant) + i) % NUM_REQ);
            if (!rr_found && bus.mgr__arb__oob_valid[idx]) begin
                rr_found = 1'b1;
                rr_sel   = idx;
            end
        end
    end

    // Outputs are gated by reset_poweron so nothing is offered to either side
    // during the reset cycle itself, even if the state is still LOCKED.
    assign locked    = (state == ST_LOCKED) && reset_poweron;
    assign out_valid = locked && bus.mgr__arb__oob_valid[grant_id];
    assign beat_xfer = out_valid && bus.std__arb__oob_ready;
    assign beat_last = (req_cntl[grant_id] == CNTL_EOM) || (req_cntl[grant_id] == CNTL_SOM_EOM);

    always_comb begin
        bus.arb__mgr__oob_ready = '0;
        if (locked) begin
            bus.arb__mgr__oob_ready[grant_id] = bus.std__arb__oob_ready;
        end
        bus.arb__std__oob_valid = out_valid;
        bus.arb__std__oob_cntl  = locked ? req_cntl[grant_id] : 2'b00;
        bus.arb__std__oob_type  = locked ? req_type[grant_id] : '0;
        bus.arb__std__oob_data  = locked ? req_data[grant_id] : '0;
    end

    always_ff @(posedge clk) begin
        if (!reset_poweron) begin
            state      <= ST_IDLE;
            last_grant <= GRANT_W'(NUM_REQ - 1);
            grant_id   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rr_found) begin
                        grant_id <= rr_sel;
                        state    <= ST_LOCKED;
                    end
                end
                default: begin
                    if ((beat_xfer && beat_last) || tmo_hit) begin
                        last_grant <= grant_id;
                        state      <= ST_IDLE;
                    end
                end
            endcase
        end
    end

`ifdef MGR_OOB_ARB_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_flag;

    // A stalled lock is dropped once the counter saturates; a beat moving on
    // that same cycle takes precedence and restarts the count instead.
    assign tmo_hit = (state == ST_LOCKED) && !beat_xfer && (tmo_cnt == '1);

    always_ff @(posedge clk) begin
        if (!reset_poweron) begin
            tmo_cnt  <= '0;
            tmo_flag <= 1'b0;
        end else begin
            if ((state != ST_LOCKED) || beat_xfer || tmo_hit) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
            if (tmo_hit) begin
                tmo_flag <= 1'b1;
            end
        end
    end

    assign arb__sys__timeout = tmo_flag;
`else
    assign tmo_hit           = 1'b0;
    assign arb__sys__timeout = 1'b0;
`endif

    assign arb__sys__grant_id = grant_id;
    assign arb__sys__busy     = (state == ST_LOCKED);

endmodule

// File: tb/tb_mgr_oob_downstream_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mgr_oob_downstream_arbiter
//   Directed bench for mgr_oob_downstream_arbiter. Inputs are changed on the
//   falling clock edge and outputs are sampled 1 time unit later, so every
//   sample reflects the state registered on the preceding rising edge.
// ----------------------------------------------------------------------------
module tb_mgr_oob_downstream_arbiter;

    localparam int NUM_REQ = 64;
    localparam int TYPE_W  = 2;
    localparam int DATA_W  = 32;
    localparam int GRANT_W = 6;
    localparam int TMO_W   = 4;

    logic               clk;
    logic               reset_poweron;
    logic [GRANT_W-1:0] grant_id;
    logic               busy;
    logic               timeout;

    int n_cmp;
    int n_bad;

    mgr_oob_downstream_arbiter_if #(.NUM_REQ(NUM_REQ), .TYPE_W(TYPE_W), .DATA_W(DATA_W)) bus ();

    mgr_oob_downstream_arbiter #(
        .NUM_REQ(NUM_REQ), .TYPE_W(TYPE_W), .DATA_W(DATA_W), .GRANT_W(GRANT_W), .TMO_W(TMO_W)
    ) dut (
        .clk                (clk),
        .reset_poweron      (reset_poweron),
        .bus                (bus),
        .arb__sys__grant_id (grant_id),
        .arb__sys__busy     (busy),
        .arb__sys__timeout  (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [NUM_REQ-1:0] onehot(input int idx);
        logic [NUM_REQ-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Requester type field is always driven as the low bits of its index.
    task automatic set_req(input int idx, input logic v, input logic [1:0] c, input logic [31:0] d);
        bus.mgr__arb__oob_valid[idx]             = v;
        bus.mgr__arb__oob_cntl[2*idx +: 2]       = c;
        bus.mgr__arb__oob_type[TYPE_W*idx +: 2]  = 2'(idx);
        bus.mgr__arb__oob_data[DATA_W*idx +: 32] = d;
    endtask

    task automatic clear_reqs();
        bus.mgr__arb__oob_valid = '0;
        bus.mgr__arb__oob_cntl  = '0;
        bus.mgr__arb__oob_type  = '0;
        bus.mgr__arb__oob_data  = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset_poweron = 1'b0;
        clear_reqs();
        bus.std__arb__oob_ready = 1'b1;
        @(negedge clk);
        reset_poweron = 1'b1;
    endtask

    task automatic test_reset();
        reset_poweron = 1'b0;
        clear_reqs();
        bus.std__arb__oob_ready = 1'b1;
        set_req(7, 1'b1, 2'b00, 32'h77);
        @(negedge clk); #1;
        n_cmp++; if (bus.arb__std__oob_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %0h want 0", bus.arb__std__oob_valid); end
        n_cmp++; if (bus.arb__mgr__oob_ready !== '0) begin n_bad++; $display("FAIL rst_ready: got %0h want 0", bus.arb__mgr__oob_ready); end
        n_cmp++; if (grant_id !== 6'd0) begin n_bad++; $display("FAIL rst_grant: got %0d want 0", grant_id); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %0h want 0", busy); end
        n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL rst_timeout: got %0h want 0", timeout); end
        n_cmp++; if (bus.arb__std__oob_data !== 32'h0) begin n_bad++; $display("FAIL rst_data: got %0h want 0", bus.arb__std__oob_data); end
        clear_reqs();
        reset_poweron = 1'b1;
    endtask

    task automatic test_single_packet();
        logic [1:0] c [3];
        c[0] = 2'b01; c[1] = 2'b11; c[2] = 2'b10;
        apply_reset();
        @(negedge clk);
        set_req(2, 1'b1, c[0], 32'hA0);
        #1;
        n_cmp++; if (bus.arb__std__oob_valid !== 1'b0) begin n_bad++; $display("FAIL t1_bubble_valid: got %0h want 0", bus.arb__std__oob_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL t1_bubble_busy: got %0h want 0", busy); end
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            set_req(2, 1'b1, c[b], 32'hA0 + 32'(b));
            #1;
            n_cmp++; if (bus.arb__std__oob_valid !== 1'b1) begin n_bad++; $display("FAIL t1_valid[%0d]: got %0h want 1", b, bus.arb__std__oob_valid); end
            n_cmp++; if (bus.arb__std__oob_cntl !== c[b]) begin n_bad++; $display("FAIL t1_cntl[%0d]: got %0h want %0h", b, bus.arb__std__oob_cntl, c[b]); end
            n_cmp++; if (bus.arb__std__oob_data !== 32'hA0 + 32'(b)) begin n_bad++; $display("FAIL t1_data[%0d]: got %0h want %0h", b, bus.arb__std__oob_data, 32'hA0 + 32'(b)); end
            n_cmp++; if (bus.arb__std__oob_type !== 2'd2) begin n_bad++; $display("FAIL t1_type[%0d]: got %0h want 2", b, bus.arb__std__oob_type); end
            n_cmp++; if (grant_id !== 6'd2) begin n_bad++; $display("FAIL t1_grant[%0d]: got %0d want 2", b, grant_id); end
            n_cmp++; if (bus.arb__mgr__oob_ready !== onehot(2)) begin n_bad++; $display("FAIL t1_ready[%0d]: got %0h want %0h", b, bus.arb__mgr__oob_ready, onehot(2)); end
        end
        @(negedge clk);
        clear_reqs();
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL t1_idle_busy: got %0h want 0", busy); end
        n_cmp++; if (bus.arb__std__oob_valid !== 1'b0) begin n_bad++; $display("FAIL t1_idle_valid: got %0h want 0", bus.arb__std__oob_valid); end
        n_cmp++; if (grant_id !== 6'd2) begin n_bad++; $display("FAIL t1_idle_grant: got %0d want 2", grant_id); end
    endtask

    task automatic test_round_robin();
        int order [3];
        order[0] = 0; order[1] = 1; order[2] = 3;
        apply_reset();
        @(negedge clk);
        for (int k = 0; k < 3; k++) set_req(order[k], 1'b1, 2'b00, 32'hD0 + 32'(order[k]));
        #1;
        n_cmp++; if (bus.arb__std__oob_valid !== 1'b0) begin n_bad++; $display("FAIL t2_bubble: got %0h want 0", bus.arb__std__oob_valid); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            n_cmp++; if (grant_id !== 6'(order[k])) begin n_bad++; $display("FAIL t2_grant[%0d]: got %0d want %0d", k, grant_id, order[k]); end
            n_cmp++; if (bus.arb__std__oob_valid !== 1'b1) begin n_bad++; $display("FAIL t2_valid[%0d]: got %0h want 1", k, bus.arb__std__oob_valid); end
            n_cmp++; if (bus.arb__std__oob_data !== 32'hD0 + 32'(order[k])) begin n_bad++; $display("FAIL t2_data[%0d]: got %0h want %0h", k, bus.arb__std__oob_data, 32'hD0 + 32'(order[k])); end
            @(negedge clk);
            set_req(order[k], 1'b0, 2'b00, 32'h0);
            #1;
            n_cmp++; if (bus.arb__std__oob_valid !== 1'b0) begin n_bad++; $display("FAIL t2_gap_valid[%0d]: got %0h want 0", k, bus.arb__std__oob_valid); end
            n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL t2_gap_busy[%0d]: got %0h want 0", k, busy); end
        end
    endtask

    task automatic test_lock_hold();
        logic [1:0] c [4];
        c[0] = 2'b01; c[1] = 2'b11; c[2] = 2'b11; c[3] = 2'b10;
        apply_reset();
        @(negedge clk);
        set_req(1, 1'b1, c[0], 32'h10);
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            set_req(1, 1'b1, c[b], 32'h10 + 32'(b));
            if (b == 1) set_req(0, 1'b1, 2'b00, 32'hE0);
            #1;
            n_cmp++; if (grant_id !== 6'd1) begin n_bad++; $display("FAIL t3_grant[%0d]: got %0d want 1", b, grant_id); end
            n_cmp++; if (bus.arb__std__oob_data !== 32'h10 + 32'(b)) begin n_bad++; $display("FAIL t3_data[%0d]: got %0h want %0h", b, bus.arb__std__oob_data, 32'h10 + 32'(b)); end
            n_cmp++; if (bus.arb__mgr__oob_ready !== onehot(1)) begin n_bad++; $display("FAIL t3_ready[%0d]: got %0h want %0h", b, bus.arb__mgr__oob_ready, onehot(1)); end
        end
        @(negedge clk);
        set_req(1, 1'b0, 2'b00, 32'h0);
        #1;
        n_cmp++; if (bus.arb__std__oob_valid !== 1'b0) begin n_bad++; $display("FAIL t3_gap: got %0h want 0", bus.arb__std__oob_valid); end
        @(negedge clk); #1;
        n_cmp++; if (grant_id !== 6'd0) begin n_bad++; $display("FAIL t3_req0_grant: got %0d want 0", grant_id); end
        n_cmp++; if (bus.arb__std__oob_data !== 32'hE0) begin n_bad++; $display("FAIL t3_req0_data: got %0h want e0", bus.arb__std__oob_data); end
        n_cmp++; if (bus.arb__mgr__oob_ready !== onehot(0)) begin n_bad++; $display("FAIL t3_req0_ready: got %0h want %0h", bus.arb__mgr__oob_ready, onehot(0)); end
        @(negedge clk);
        clear_reqs();
    endtask

    task automatic test_backpressure();
        apply_reset();
        @(negedge clk);
        set_req(5, 1'b1, 2'b01, 32'h50);
        // Locked cycle 0: ready=1, SOM transfers.
        @(negedge clk);
        bus.std__arb__oob_ready = 1'b1;
        #1;
        n_cmp++; if (bus.arb__std__oob_data !== 32'h50) begin n_bad++; $display("FAIL t4_som_data: got %0h want 50", bus.arb__std__oob_data); end
        n_cmp++; if (bus.arb__mgr__oob_ready !== onehot(5)) begin n_bad++; $display("FAIL t4_som_ready: got %0h want %0h", bus.arb__mgr__oob_ready, onehot(5)); end
        // Locked cycle 1: ready=0, EOM presented but held.
        @(negedge clk);
        set_req(5, 1'b1, 2'b10, 32'h51);
        bus.std__arb__oob_ready = 1'b0;
        #1;
        n_cmp++; if (bus.arb__std__oob_data !== 32'h51) begin n_bad++; $display("FAIL t4_hold_data: got %0h want 51", bus.arb__std__oob_data); end
        n_cmp++; if (bus.arb__mgr__oob_ready !== '0) begin n_bad++; $display("FAIL t4_hold_ready: got %0h want 0", bus.arb__mgr__oob_ready); end
        // Locked cycle 2: ready=1, EOM transfers.
        @(negedge clk);
        bus.std__arb__oob_ready = 1'b1;
        #1;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL t4_still_busy: got %0h want 1", busy); end
        n_cmp++; if (bus.arb__std__oob_data !== 32'h51) begin n_bad++; $display("FAIL t4_eom_data: got %0h want 51", bus.arb__std__oob_data); end
        n_cmp++; if (bus.arb__std__oob_cntl !== 2'b10) begin n_bad++; $display("FAIL t4_eom_cntl: got %0h want 2", bus.arb__std__oob_cntl); end
        @(negedge clk);
        bus.std__arb__oob_ready = 1'b0;
        clear_reqs();
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL t4_done_busy: got %0h want 0", busy); end
        bus.std__arb__oob_ready = 1'b1;
    endtask

    task automatic test_reset_mid_packet();
        apply_reset();
        @(negedge clk);
        set_req(3, 1'b1, 2'b01, 32'h30);
        @(negedge clk);
        @(negedge clk);
        set_req(3, 1'b1, 2'b11, 32'h31);
        // Beat 2 cycle: reset asserted, req0 joins.
        @(negedge clk);
        set_req(3, 1'b1, 2'b11, 32'h32);
        set_req(0, 1'b1, 2'b00, 32'hF0);
        reset_poweron = 1'b0;
        #1;
        n_cmp++; if (bus.arb__std__oob_valid !== 1'b0) begin n_bad++; $display("FAIL t5_rst_valid: got %0h want 0", bus.arb__std__oob_valid); end
        n_cmp++; if (bus.arb__mgr__oob_ready !== '0) begin n_bad++; $display("FAIL t5_rst_ready: got %0h want 0", bus.arb__mgr__oob_ready); end
        @(negedge clk);
        reset_poweron = 1'b1;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL t5_after_busy: got %0h want 0", busy); end
        n_cmp++; if (grant_id !== 6'd0) begin n_bad++; $display("FAIL t5_after_grant: got %0d want 0", grant_id); end
        n_cmp++; if (bus.arb__std__oob_valid !== 1'b0) begin n_bad++; $display("FAIL t5_after_valid: got %0h want 0", bus.arb__std__oob_valid); end
        @(negedge clk); #1;
        n_cmp++; if (grant_id !== 6'd0) begin n_bad++; $display("FAIL t5_prio_grant: got %0d want 0", grant_id); end
        n_cmp++; if (bus.arb__std__oob_data !== 32'hF0) begin n_bad++; $display("FAIL t5_prio_data: got %0h want f0", bus.arb__std__oob_data); end
        @(negedge clk);
        clear_reqs();
    endtask

    task automatic test_timeout();
        apply_reset();
        @(negedge clk);
        set_req(4, 1'b1, 2'b01, 32'h40);
        @(negedge clk); #1;
        n_cmp++; if (grant_id !== 6'd4) begin n_bad++; $display("FAIL t6_grant: got %0d want 4", grant_id); end
        @(negedge clk);
        set_req(4, 1'b0, 2'b11, 32'h41);
`ifdef MGR_OOB_ARB_TIMEOUT_EN
        // Counter reaches all-ones after 15 stalled edges; the 16th releases.
        for (int s = 0; s < 16; s++) begin
            if (s > 0) @(negedge clk);
            #1;
            n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL t6_stall_busy[%0d]: got %0h want 1", s, busy); end
            n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL t6_stall_tmo[%0d]: got %0h want 0", s, timeout); end
        end
        @(negedge clk); #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL t6_forced_idle: got %0h want 0", busy); end
        n_cmp++; if (timeout !== 1'b1) begin n_bad++; $display("FAIL t6_flag: got %0h want 1", timeout); end
        repeat (3) @(negedge clk);
        #1;
        n_cmp++; if (timeout !== 1'b1) begin n_bad++; $display("FAIL t6_sticky: got %0h want 1", timeout); end
        apply_reset();
        #1;
        n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL t6_cleared: got %0h want 0", timeout); end
`else
        // Without the timeout feature the lock must survive a long stall.
        for (int s = 0; s < 20; s++) begin
            @(negedge clk); #1;
            n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL t6_hold_busy[%0d]: got %0h want 1", s, busy); end
            n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL t6_no_tmo[%0d]: got %0h want 0", s, timeout); end
        end
        apply_reset();
`endif
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_single_packet();
        test_round_robin();
        test_lock_hold();
        test_backpressure();
        test_reset_mid_packet();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Safety net: every test is a fixed-length directed sequence, so this
    // only fires if simulation time somehow runs away.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule
